// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with its sequencing FSM.
// Build option: define DIV_ZERO_SHORTCUT_EN to send a zero dividend down the fast zero path.
module div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic [1:0]            state_dbg
);

  // Handshake: start_i is a level request held by the requester; ready_o rises
  // once result_o is valid and both hold until start_i drops, which returns the
  // FSM to FREE on that edge (ready_o and result_o cleared together).
  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dsr_q, dsr_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0]   result_d;
  logic                  ready_d;

  logic                  zero_path;
  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W:0]       rem_sh, diff;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

`ifdef DIV_ZERO_SHORTCUT_EN
  assign zero_path = (opdata2_i == '0) || (opdata1_i == '0);
`else
  assign zero_path = (opdata2_i == '0);
`endif

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // The quotient bits shift into dvd_q as dividend bits shift out of it.
  assign rem_sh  = {rem_q, dvd_q[DATA_W-1]};
  assign diff    = rem_sh - {1'b0, dsr_q};
  assign quo_fix = quo_neg_q ? -dvd_q : dvd_q;
  assign rem_fix = rem_neg_q ? -rem_q : rem_q;

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) state_d = zero_path ? S_BYZERO : S_ON;
      end
      S_BYZERO: state_d = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)                state_d = S_FREE;
        else if (cnt_q == LAST_CNT) state_d = S_END;
      end
      S_END: begin
        if (!start_i) state_d = S_FREE;
      end
      default: state_d = S_FREE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_o;
    ready_d   = ready_o;
    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (state_d == S_ON) begin
          cnt_d     = '0;
          rem_d     = '0;
          dvd_d     = op1_abs;
          dsr_d     = op2_abs;
          quo_neg_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          rem_neg_d = signed_div_i && opdata1_i[DATA_W-1];
        end
      end
      S_BYZERO: begin
        result_d = '0;
        ready_d  = !annul_i;
      end
      S_ON: begin
        if (annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != LAST_CNT) begin
          rem_d = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

endmodule
